// File: rtl/iir_tdm_pkg.sv
// iir_tdm_pkg: shared types and constants for the TDM biquad core
package iir_tdm_pkg;
  localparam int NUM_TAPS = 5;
  typedef enum logic [2:0] {B0, B1, B2, A1, A2} coef_idx_e;
  typedef enum logic [1:0] {IDLE, MAC, OUT} fsm_e;
endpackage

// File: rtl/iir_round_sat.sv
// iir_round_sat: round-to-nearest by FRAC bits, then clamp to DATA_W with a saturation flag
module iir_round_sat #(
  parameter int ACC_W  = 48,
  parameter int DATA_W = 16,
  parameter int FRAC   = 14
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_y,
  output logic                     o_sat
);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] w_r;
  always_comb begin
    w_r   = (i_acc + HALF) >>> FRAC;
    o_sat = (w_r > MAXV) || (w_r < MINV);
    o_y   = w_r > MAXV ? MAXV[DATA_W-1:0] : w_r < MINV ? MINV[DATA_W-1:0] : w_r[DATA_W-1:0];
  end
endmodule

// File: rtl/iir_biquad_tdm_core.sv
// iir_biquad_tdm_core: N_CH-channel DF-I biquad sharing one MAC, with
// double-buffered coefficients swapped only while idle between samples.
module iir_biquad_tdm_core
  import iir_tdm_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int COEF_W    = 16,
  parameter  int COEF_FRAC = 14,
  parameter  int ACC_W     = 48,
  parameter  int N_CH      = 2,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [CH_W-1:0]          s_ch,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CH_W-1:0]          m_ch,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_sat,
  input  logic                     coef_we,
  input  logic [CH_W-1:0]          coef_ch,
  input  logic [2:0]               coef_idx,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     coef_commit,
  output logic                     coef_pend,
  input  logic                     state_clr
);
  fsm_e r_state, w_next;
  logic r_live, r_pend, r_clr_pend;
  logic [2:0] r_tap;
  logic [CH_W-1:0] r_ch;
  logic signed [DATA_W-1:0] r_x;
  logic signed [ACC_W-1:0] r_acc;
  // history per channel: 0=x1 1=x2 2=y1 3=y2
  logic signed [DATA_W-1:0] r_hist [N_CH][4];
  logic signed [COEF_W-1:0] r_act [N_CH][NUM_TAPS];
  logic signed [COEF_W-1:0] r_shd [N_CH][NUM_TAPS];
  logic w_idle, w_clr, w_acc, w_done, w_copy, w_sat;
  logic [1:0] w_hidx;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [DATA_W-1:0] w_dat, w_y;
  logic signed [DATA_W+COEF_W-1:0] w_prod;

  assign w_idle    = r_state == IDLE;
  assign w_clr     = w_idle && (r_clr_pend || state_clr);
  assign s_ready   = r_live && w_idle && !(r_clr_pend || state_clr);
  assign w_acc     = s_valid && s_ready;
  assign w_done    = r_state == MAC && r_tap == 3'(NUM_TAPS);
  assign w_copy    = w_idle && r_pend;
  assign coef_pend = r_pend;
  assign w_hidx    = 2'(r_tap - 3'd1);
  assign w_coef    = r_act[r_ch][r_tap < 3'(NUM_TAPS) ? r_tap : 3'd0];
  assign w_dat     = r_tap == 3'd0 ? r_x : r_hist[r_ch][w_hidx];
  assign w_prod    = w_coef * w_dat;

  iir_round_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W), .FRAC(COEF_FRAC)) u_round_sat (
    .i_acc(r_acc),
    .o_y  (w_y),
    .o_sat(w_sat)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state == IDLE ? (w_acc ? MAC : IDLE) :
             r_state == MAC  ? (w_done ? OUT : MAC) :
             (m_ready ? IDLE : OUT);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_live     <= 1'b0;
      r_pend     <= 1'b0;
      r_clr_pend <= 1'b0;
      r_tap      <= '0;
      r_ch       <= '0;
      r_x        <= '0;
      r_acc      <= '0;
      m_valid    <= 1'b0;
      m_ch       <= '0;
      m_data     <= '0;
      m_sat      <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < 4; k++) r_hist[c][k] <= '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
          r_act[c][k] <= '0;
          r_shd[c][k] <= '0;
        end
      end
    end else begin
      r_live     <= 1'b1;
      r_pend     <= coef_commit || (r_pend && !w_idle);
      r_clr_pend <= (state_clr || r_clr_pend) && !w_idle;
      if (coef_we && coef_idx < 3'(NUM_TAPS) && 32'(coef_ch) < N_CH)
        r_shd[coef_ch][coef_idx] <= coef_wdata;
      if (w_copy) r_act <= r_shd;
      if (w_clr)
        for (int c = 0; c < N_CH; c++)
          for (int k = 0; k < 4; k++) r_hist[c][k] <= '0;
      if (w_acc) begin
        r_x   <= s_data;
        r_ch  <= 32'(s_ch) < N_CH ? s_ch : '0;
        r_tap <= '0;
        r_acc <= '0;
      end
      // feedback taps enter with negated coefficients
      if (r_state == MAC) begin
        r_tap <= r_tap + 3'd1;
        if (!w_done)
          r_acc <= r_tap >= 3'(A1) ? r_acc - ACC_W'(w_prod) : r_acc + ACC_W'(w_prod);
      end
      if (w_done) begin
        m_valid           <= 1'b1;
        m_data            <= w_y;
        m_sat             <= w_sat;
        m_ch              <= r_ch;
        r_hist[r_ch][0]   <= r_x;
        r_hist[r_ch][1]   <= r_hist[r_ch][0];
        r_hist[r_ch][2]   <= w_y;
        r_hist[r_ch][3]   <= r_hist[r_ch][2];
      end
      if (r_state == OUT && m_ready) m_valid <= 1'b0;
    end
endmodule

// File: tb/tb_iir_biquad_tdm_core.sv
// tb_iir_biquad_tdm_core: scoreboard bench with a plain-arithmetic biquad reference model
module tb_iir_biquad_tdm_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0, s_ready;
  logic s_ch = 1'b0;
  logic signed [15:0] s_data = '0;
  logic m_valid, m_ready, m_ch, m_sat;
  logic signed [15:0] m_data;
  logic coef_we = 1'b0, coef_ch = 1'b0;
  logic [2:0] coef_idx = '0;
  logic signed [15:0] coef_wdata = '0;
  logic coef_commit = 1'b0, coef_pend, state_clr = 1'b0;

  iir_biquad_tdm_core dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_data(m_data), .m_sat(m_sat),
    .coef_we(coef_we), .coef_ch(coef_ch), .coef_idx(coef_idx), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .coef_pend(coef_pend), .state_clr(state_clr)
  );

  always #5 clk = ~clk;

  typedef struct {int data; int ch; int sat; int acc_cyc;} exp_t;
  exp_t q[$];
  int act[2][5], shd[2][5], hist[2][4];
  bit m_pend, m_cpend, hold, rand_rdy, prev_mv;
  int n_cmp, n_bad, cyc;

  task automatic chk(string nm, int a, int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  // y = sat(round(b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2))
  function automatic void model_accept(int ch, int x, int at);
    longint acc, r;
    exp_t e;
    if (m_pend) begin act = shd; m_pend = 0; end
    if (m_cpend) begin hist = '{default: 0}; m_cpend = 0; end
    acc = longint'(act[ch][0]) * x + longint'(act[ch][1]) * hist[ch][0]
        + longint'(act[ch][2]) * hist[ch][1] - longint'(act[ch][3]) * hist[ch][2]
        - longint'(act[ch][4]) * hist[ch][3];
    r = (acc + 8192) >>> 14;
    e.sat = (r > 32767 || r < -32768) ? 1 : 0;
    e.data = r > 32767 ? 32767 : r < -32768 ? -32768 : int'(r);
    e.ch = ch;
    e.acc_cyc = at;
    hist[ch][1] = hist[ch][0];
    hist[ch][0] = x;
    hist[ch][3] = hist[ch][2];
    hist[ch][2] = e.data;
    q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int ch, int idx, int val);
    coef_we = 1'b1; coef_ch = 1'(ch); coef_idx = 3'(idx); coef_wdata = 16'(val);
    tick();
    coef_we = 1'b0;
    if (idx < 5) shd[ch][idx] = val;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    m_pend = 1;
  endtask

  task automatic clr();
    state_clr = 1'b1;
    tick();
    state_clr = 1'b0;
    m_cpend = 1;
  endtask

  task automatic send(int ch, int x);
    int n = 0;
    s_valid = 1'b1; s_ch = 1'(ch); s_data = 16'(x);
    forever begin
      @(negedge clk);
      if (s_ready) break;
      if (++n > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: s_ready stuck at %0d, required 1", s_ready);
        s_valid = 1'b0;
        return;
      end
    end
    model_accept(ch, x, cyc + 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d outputs missing, required 0", q.size());
      q.delete();
    end
    tick();
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    m_ready = hold ? 1'b0 : rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) prev_mv = 1'b0;
    else begin
      if (m_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: m_data=%0d with empty scoreboard", m_data);
        end else begin
          if (!prev_mv) chk("latency", cyc - q[0].acc_cyc, 6);
          chk("m_data", int'(m_data), q[0].data);
          chk("m_ch", int'(m_ch), q[0].ch);
          chk("m_sat", int'(m_sat), q[0].sat);
          if (!m_ready) chk("s_ready_while_held", int'(s_ready), 0);
          else void'(q.pop_front());
        end
      end
      prev_mv = m_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int x;
    hold = 0; rand_rdy = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready_low", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_s_ready", int'(s_ready), 1);
    chk("rel_coef_pend", int'(coef_pend), 0);
    // identity
    wr(0, 0, 16384); commit();
    send(0, 1234); drain();
    // channel isolation: ch0 low-pass impulse, ch1 identity fed zeros
    clr();
    wr(0, 0, 4000); wr(0, 1, 8000); wr(0, 2, 4000); wr(0, 3, -5000); wr(0, 4, 2000);
    wr(1, 0, 16384);
    commit();
    for (int i = 0; i < 8; i++) begin
      send(0, i == 0 ? 8192 : 0);
      send(1, 0);
    end
    drain();
    // saturation both ways
    wr(0, 0, 32767);
    for (int k = 1; k < 5; k++) wr(0, k, 0);
    commit();
    send(0, 30000); send(0, -30000); drain();
    // commit during MAC
    wr(0, 0, 16384); commit();
    send(0, 1000); drain();
    wr(0, 0, 8192);
    send(0, 4000);
    tick();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    m_pend = 1;
    @(negedge clk);
    chk("pend_in_mac", int'(coef_pend), 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pend_first_idle", int'(coef_pend), 1);
    @(posedge clk);
    @(negedge clk);
    chk("pend_cleared", int'(coef_pend), 0);
    drain();
    send(0, 4000); drain();
    // backpressure
    hold = 1; tick();
    send(1, 777);
    repeat (26) @(posedge clk);
    #1 hold = 0;
    drain();
    send(1, -500); send(0, 321); drain();
    // reset mid-MAC
    send(0, 5000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_s_ready", int'(s_ready), 0);
    q.delete();
    act = '{default: 0}; shd = '{default: 0}; hist = '{default: 0};
    m_pend = 0; m_cpend = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rel_s_ready", int'(s_ready), 1);
    chk("midrst_pend", int'(coef_pend), 0);
    wr(0, 0, 16384); wr(0, 1, 16384); commit();
    send(0, 100); send(0, 50); drain();
    // randomized traffic, coefficient swaps and clears
    rand_rdy = 1;
    for (int it = 0; it < 60; it++) begin
      x = int'($urandom_range(0, 65535)) - 32768;
      send(int'($urandom_range(0, 1)), x);
      if ($urandom_range(0, 3) == 0) begin
        x = int'($urandom_range(0, 1));
        for (int k = 0; k < 5; k++) wr(x, k, int'($urandom_range(0, 40000)) - 20000);
        commit();
      end else if ($urandom_range(0, 7) == 0) clr();
    end
    rand_rdy = 0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
